serial_addsub_n: RTL
====================

Name: serial_addsub_n

Overview:
- Parametrised bit-serial adder/subtractor, W-bit operands, processed LSB-first with one bit per clock.
- Operands are captured on a start handshake and shifted through a single full-adder slice with a registered carry.
- Produces a W-bit result with carry-out and signed overflow, plus busy/done status.
- Used wherever area matters more than latency, in place of a W-bit parallel adder.

Parameters:
- W, 8, operand and result width in bits; legal range W >= 2.
- CW, $clog2(W), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when not busy.
- sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- busy  output  1  high while serial computation is in progress.
- done  output  1  one-cycle pulse when result/cout/overflow update.
- result  output  W  sum/difference; holds last completed value.
- cout  output  1  carry out of MSB; for sub, 1 means a >= b (unsigned, no borrow).
- overflow  output  1  signed (two's complement) overflow of last operation.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; internal shift registers, carry and counter cleared. This applies mid-operation: the operation in progress is abandoned and no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load opA=a, opB=(sub ? ~b : b), carry=sub, count=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - s = opA[0]^opB[0]^carry.
  - c = majority(opA[0], opB[0], carry).
  - acc shifts right with s into acc[W-1]; opA and opB shift right; carry=c; count++.
  - At the edge where count==W-1, also latch result=final acc value, cout=c, overflow=(carry into MSB)^c, and go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1: accept exactly as from IDLE (back-to-back, go to SHIFT).
  - start=0: go to IDLE.
- busy=1 only in SHIFT. done=1 only in DONE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+W. Throughput is one operation per W+1 cycles.
- start, sub, a, b are ignored while busy. Input changes during SHIFT have no effect.
- result, cout and overflow do not change during SHIFT; intermediate bits are never visible. They change only at the completing edge and hold until the next completion or reset.
- Arithmetic is modulo 2^W.
- Subtraction uses a + ~b + 1: the carry is preset to 1 and the inverted B is loaded.
- overflow equals XOR of carry-in and carry-out at bit W-1.

Test Plan:
- W=8, add 100+55 (0x64+0x37) -> done 8 cycles after start; result=0x9B, cout=0, overflow=1; busy high exactly 8 cycles.
- W=8, add 200+100 -> result=0x2C, cout=1, overflow=0; then sub 5-7 -> result=0xFE, cout=0, overflow=0.
- W=8, sub 0x80-0x01 -> result=0x7F, cout=1, overflow=1; sub 0x00-0x00 -> result=0x00, cout=1, overflow=0.
- Start 0x0F+0x01, then pulse start with a=0xFF/b=0xFF and toggle a/b/sub during SHIFT -> ignored; result=0x10. Assert start in the DONE cycle with 0x01+0x01 -> accepted, result=0x02 W+1 cycles later.
- Complete 0x12+0x34 (result=0x46), start 0xFF+0x01, drop rst_n after 3 SHIFT cycles -> immediately busy=0, done=0, result=0, cout=0, overflow=0; no done pulse follows; a new start after release computes correctly.
- W=16, add 0xFFFF+0x0001 -> after 16 cycles result=0x0000, cout=1, overflow=0; sub 0x8000-0x7FFF -> result=0x0001, cout=1, overflow=1.

Source files
------------

// File: rtl/serial_addsub_n.sv
// Bit-serial W-bit adder/subtractor, LSB first, one bit per clock.
// One full-adder slice with a registered carry; result latched on completion.
module serial_addsub_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  acc;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          s;
  logic          c;
  logic          last;
  logic          accept;
  logic [W-1:0]  acc_n;

  assign s      = op_a[0] ^ op_b[0] ^ carry;
  assign c      = (op_a[0] & op_b[0])
                | (op_a[0] & carry)
                | (op_b[0] & carry);
  assign last   = (cnt == CW'(W - 1));
  assign accept = start && (state != SHIFT);
  assign acc_n  = {s, acc[W-1:1]};
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last) state_n = DONE;
      DONE:    state_n = start ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      unique case (1'b1)
        accept: begin
          // Subtract as a + ~b + 1: invert B, preset carry.
          op_a  <= a;
          op_b  <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
          acc   <= '0;
        end
        busy: begin
          acc   <= acc_n;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= c;
          cnt   <= cnt + CW'(1);
          if (last) begin
            result   <= acc_n;
            cout     <= c;
            overflow <= carry ^ c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
